keypad_event_fifo: RTL and testbench

Parametrised keypad front end for the MCU I/O path. It scans a ROWS×COLS matrix keypad, debounces the frames and reduces each stable frame to a single key code. Press and optional release events are queued in a FIFO, which the MCU drains through its 8-bit KB input with a valid/ack handshake. It replaces the fixed 4×4 combinational decode with configurable geometry, debounce, buffering and overflow reporting.

---
 rtl/keypad_event_fifo.sv | 235 +++++++++++++++++++++++
 tb/tb_keypad_event_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_fifo.sv
// Matrix keypad scanner with frame debounce. Press (and optional release)
// events are queued in a FIFO that the MCU drains with a valid/ack handshake.
module keypad_event_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int REL_EVT    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS-1:0]               Keypad_rows,
  output logic [COLS-1:0]               Keypad_cols,
  output logic [7:0]                    key_code,
  output logic                          key_valid,
  input  logic                          key_ack,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int NKEYS = ROWS * COLS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNTW  = PW + 1;

  // Key indices are 0..63, so bit 6 alone marks "no key".
  localparam logic [6:0]      KEY_NONE   = 7'h40;
  localparam logic [CW-1:0]   COL_LAST   = CW'(COLS - 1);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      RUN_MAX    = 4'(DEBOUNCE);
  localparam logic [CNTW-1:0] FIFO_FULL  = CNTW'(FIFO_DEPTH);
  localparam logic            REL_ON     = (REL_EVT != 0);

  logic [CW-1:0]    col_q, col_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [COLS-1:0]  cols_q, cols_d;
  logic [NKEYS-1:0] frame_q, frame_d;
  logic             sample_s;
  logic             frame_done_s;
  logic [6:0]       code_s;

  logic [6:0]       prev_q, prev_d;
  logic [3:0]       run_q, run_d, run_next_s;
  logic [6:0]       state_q, state_d;
  logic             accept_s;
  logic             rel_s;
  logic             prs_s;

  logic             pend_q, pend_d;
  logic [7:0]       pend_code_q, pend_code_d;
  logic             push_s;
  logic [7:0]       push_data_s;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             pop_s;
  logic             full_s;
  logic             wr_en_s;
  logic             drop_s;
  logic             ovf_q, ovf_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;

  assign sample_s     = (dwell_q == DWELL_LAST);
  assign frame_done_s = sample_s && (col_q == COL_LAST);

  // Column scan: sample the rows at the end of each dwell, then move on.
  always_comb begin
    col_d   = col_q;
    dwell_d = dwell_q + DW'(1'b1);
    frame_d = frame_q;
    if (sample_s) begin
      dwell_d = '0;
      frame_d[int'(col_q) * ROWS +: ROWS] = ~Keypad_rows;
      if (col_q == COL_LAST) begin
        col_d = '0;
      end else begin
        col_d = col_q + CW'(1'b1);
      end
    end else begin
      col_d = col_q;
    end
    cols_d = ~(COLS'(1'b1) << col_d);
  end

  // Lowest-index pressed key of the frame including this cycle's sample.
  always_comb begin
    code_s = KEY_NONE;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (frame_d[i]) begin
        code_s = 7'(i);
      end else begin
        code_s = code_s;
      end
    end
  end

  // Debounce run length and accepted-state tracking, once per frame.
  always_comb begin
    if (code_s == prev_q) begin
      if (run_q == RUN_MAX) begin
        run_next_s = run_q;
      end else begin
        run_next_s = run_q + 4'd1;
      end
    end else begin
      run_next_s = 4'd1;
    end
    accept_s = frame_done_s && (run_next_s == RUN_MAX) && (code_s != state_q);
    rel_s    = accept_s && REL_ON && (state_q != KEY_NONE);
    prs_s    = accept_s && (code_s != KEY_NONE);
    if (frame_done_s) begin
      prev_d = code_s;
      run_d  = run_next_s;
    end else begin
      prev_d = prev_q;
      run_d  = run_q;
    end
    if (accept_s) begin
      state_d = code_s;
    end else begin
      state_d = state_q;
    end
  end

  // A release pushes now and parks the press for the following cycle.
  always_comb begin
    pend_d      = 1'b0;
    pend_code_d = pend_code_q;
    push_s      = 1'b0;
    push_data_s = 8'hFF;
    if (rel_s) begin
      push_s      = 1'b1;
      push_data_s = {2'b10, state_q[5:0]};
      pend_d      = prs_s;
      pend_code_d = {2'b00, code_s[5:0]};
    end else if (prs_s) begin
      push_s      = 1'b1;
      push_data_s = {2'b00, code_s[5:0]};
    end else if (pend_q) begin
      push_s      = 1'b1;
      push_data_s = pend_code_q;
    end else begin
      push_s      = 1'b0;
    end
  end

  // FIFO bookkeeping; the head is precomputed so the outputs stay registered.
  always_comb begin
    pop_s       = key_ack && key_valid_q;
    full_s      = (count_q == FIFO_FULL);
    wr_en_s     = push_s && (!full_s || pop_s);
    drop_s      = push_s && full_s && !pop_s;
    wr_d        = wr_q + PW'(wr_en_s);
    rd_d        = rd_q + PW'(pop_s);
    count_d     = count_q + CNTW'(wr_en_s) - CNTW'(pop_s);
    key_valid_d = (count_d != '0);
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (count_d == '0) begin
      key_code_d = 8'hFF;
    end else if (wr_en_s && (wr_q == rd_d)) begin
      key_code_d = push_data_s;
    end else begin
      key_code_d = mem_q[rd_d];
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      dwell_q     <= '0;
      cols_q      <= ~(COLS'(1'b1));
      frame_q     <= '0;
      prev_q      <= KEY_NONE;
      run_q       <= 4'd0;
      state_q     <= KEY_NONE;
      pend_q      <= 1'b0;
      pend_code_q <= 8'h00;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      key_code_q  <= 8'hFF;
      key_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      cols_q      <= cols_d;
      frame_q     <= frame_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Event storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'hFF;
      end
    end else if (wr_en_s) begin
      mem_q[wr_q] <= push_data_s;
    end else begin
      mem_q[wr_q] <= mem_q[wr_q];
    end
  end

  assign Keypad_cols = cols_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign overflow    = ovf_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Bench for keypad_event_fifo: three instances (defaults, release events,
// two-deep FIFO) driven by a keypad model, with per-instance scoreboards.
module tb_keypad_event_fifo;

  localparam int FRAME = 64;

  typedef struct packed {
    logic [15:0] mask;
    logic [7:0]  frames;
    logic [7:0]  n;
    logic [7:0]  code;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   t;

  logic [15:0] mask_a, mask_r, mask_o;
  logic [3:0]  rows_a, rows_r, rows_o, cols_a, cols_r, cols_o;
  logic [7:0]  code_a, code_r, code_o;
  logic        valid_a, valid_r, valid_o, ack_a, ack_r, ack_o;
  logic        ovf_a, ovf_r, ovf_o, clr_a, clr_r, clr_o;
  logic [2:0]  cnt_a, cnt_r;
  logic [1:0]  cnt_o;
  logic [7:0]  sb_a[$], sb_r[$], sb_o[$];
  vec_t        vec [9];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [3:0] rows_of(input logic [15:0] m, input logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!cols[c]) r = r & ~m[c*4 +: 4];
    end
    return r;
  endfunction

  assign rows_a = rows_of(mask_a, cols_a);
  assign rows_r = rows_of(mask_r, cols_r);
  assign rows_o = rows_of(mask_o, cols_o);

  keypad_event_fifo dut_a (
    .clk(clk), .rst(rst), .Keypad_rows(rows_a), .Keypad_cols(cols_a),
    .key_code(code_a), .key_valid(valid_a), .key_ack(ack_a),
    .overflow(ovf_a), .clr_ovf(clr_a), .fifo_count(cnt_a));

  keypad_event_fifo #(.REL_EVT(1)) dut_r (
    .clk(clk), .rst(rst), .Keypad_rows(rows_r), .Keypad_cols(cols_r),
    .key_code(code_r), .key_valid(valid_r), .key_ack(ack_r),
    .overflow(ovf_r), .clr_ovf(clr_r), .fifo_count(cnt_r));

  keypad_event_fifo #(.FIFO_DEPTH(2)) dut_o (
    .clk(clk), .rst(rst), .Keypad_rows(rows_o), .Keypad_cols(cols_o),
    .key_code(code_o), .key_valid(valid_o), .key_ack(ack_o),
    .overflow(ovf_o), .clr_ovf(clr_o), .fifo_count(cnt_o));

  function automatic void chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // Scoreboards: every popped head must match the oldest expected event.
  always @(negedge clk) begin
    if (ack_a && valid_a) begin
      if (sb_a.size() == 0) chk("a_pop_unexpected", int'(code_a), -1);
      else chk("a_pop", int'(code_a), int'(sb_a.pop_front()));
    end
    if (ack_r && valid_r) begin
      if (sb_r.size() == 0) chk("r_pop_unexpected", int'(code_r), -1);
      else chk("r_pop", int'(code_r), int'(sb_r.pop_front()));
    end
    if (ack_o && valid_o) begin
      if (sb_o.size() == 0) chk("o_pop_unexpected", int'(code_o), -1);
      else chk("o_pop", int'(code_o), int'(sb_o.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int tc);
    while (cyc < tc) tick();
  endtask

  task automatic drain(input int which);
    for (int k = 0; k < 8; k++) begin
      if (which == 0 && valid_a) ack_a = 1'b1;
      else if (which == 1 && valid_r) ack_r = 1'b1;
      else if (which == 2 && valid_o) ack_o = 1'b1;
      else break;
      tick();
      ack_a = 1'b0; ack_r = 1'b0; ack_o = 1'b0;
    end
    ack_a = 1'b0; ack_r = 1'b0; ack_o = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{16'h0000, 8'd3, 8'd0, 8'hFF};
    vec[1] = '{16'h0001, 8'd2, 8'd0, 8'hFF};
    vec[2] = '{16'h0000, 8'd3, 8'd0, 8'hFF};
    vec[3] = '{16'h8000, 8'd3, 8'd1, 8'h0F};
    vec[4] = '{16'h8000, 8'd2, 8'd0, 8'hFF};
    vec[5] = '{16'h0008, 8'd3, 8'd1, 8'h03};
    vec[6] = '{16'h1040, 8'd3, 8'd1, 8'h06};
    vec[7] = '{16'h0000, 8'd3, 8'd0, 8'hFF};
    vec[8] = '{16'h0400, 8'd3, 8'd1, 8'h0A};

    rst = 1'b1;
    ack_a = 1'b0; ack_r = 1'b0; ack_o = 1'b0;
    clr_a = 1'b0; clr_r = 1'b0; clr_o = 1'b0;
    mask_a = 16'h0200; mask_r = 16'h0000; mask_o = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_cols", int'(cols_a), 32'hE);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_code", int'(code_a), 32'hFF);
    chk("rst_count", int'(cnt_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    wait_until(16);
    chk("scan_col1", int'(cols_a), 32'hD);
    wait_until(63);
    chk("scan_col3", int'(cols_a), 32'h7);

    // Key 9 held from reset: accepted at the end of frame 3.
    sb_a.push_back(8'h09);
    wait_until(3 * FRAME - 1);
    chk("lat_valid_early", int'(valid_a), 0);
    tick();
    chk("lat_valid", int'(valid_a), 1);
    chk("lat_code", int'(code_a), 32'h09);
    chk("lat_count", int'(cnt_a), 1);
    wait_until(4 * FRAME);
    chk("held_count", int'(cnt_a), 1);

    t = 4 * FRAME;
    for (int i = 0; i < 9; i++) begin
      mask_a = vec[i].mask;
      if (vec[i].n != 8'd0) sb_a.push_back(vec[i].code);
      drain(0);
      t = t + int'(vec[i].frames) * FRAME;
      wait_until(t);
      chk($sformatf("vec%0d_count", i), int'(cnt_a), int'(vec[i].n));
      chk($sformatf("vec%0d_head", i), int'(code_a), int'(vec[i].code));
    end
    drain(0);
    chk("a_sb_empty", sb_a.size(), 0);

    // Release events: press then release, then a direct 5 -> 7 change.
    mask_r = 16'h0020;
    sb_r.push_back(8'h05);
    sb_r.push_back(8'h85);
    t = t + 5 * FRAME;
    wait_until(t);
    mask_r = 16'h0000;
    t = t + 3 * FRAME;
    wait_until(t);
    chk("rel_count", int'(cnt_r), 2);
    chk("rel_head", int'(code_r), 32'h05);
    drain(1);
    mask_r = 16'h0020;
    sb_r.push_back(8'h05);
    t = t + 3 * FRAME;
    wait_until(t);
    chk("rel_press_count", int'(cnt_r), 1);
    mask_r = 16'h0080;
    sb_r.push_back(8'h85);
    sb_r.push_back(8'h07);
    drain(1);
    t = t + 3 * FRAME;
    wait_until(t);
    chk("pair_first_count", int'(cnt_r), 1);
    chk("pair_first_head", int'(code_r), 32'h85);
    tick();
    chk("pair_second_count", int'(cnt_r), 2);
    drain(1);
    chk("r_sb_empty", sb_r.size(), 0);

    // Overflow on a two-deep FIFO: the third press is dropped.
    mask_o = 16'h0002;
    sb_o.push_back(8'h01);
    t = t + 3 * FRAME;
    wait_until(t);
    mask_o = 16'h0004;
    sb_o.push_back(8'h02);
    t = t + 3 * FRAME;
    wait_until(t);
    mask_o = 16'h0008;
    t = t + 3 * FRAME;
    wait_until(t);
    chk("ovf_count", int'(cnt_o), 2);
    chk("ovf_head", int'(code_o), 32'h01);
    chk("ovf_set", int'(ovf_o), 1);
    clr_o = 1'b1;
    tick();
    clr_o = 1'b0;
    chk("ovf_clr", int'(ovf_o), 0);

    // Full FIFO with push and pop on the same cycle.
    mask_o = 16'h0010;
    sb_o.push_back(8'h04);
    t = t + 3 * FRAME;
    wait_until(t - 1);
    ack_o = 1'b1;
    tick();
    ack_o = 1'b0;
    chk("pp_count", int'(cnt_o), 2);
    chk("pp_head", int'(code_o), 32'h02);
    chk("pp_ovf", int'(ovf_o), 0);
    drain(2);
    chk("o_sb_empty", sb_o.size(), 0);

    // Reset in the middle of column 2 with one entry queued.
    mask_a = 16'h0200;
    sb_a.push_back(8'h09);
    t = t + 3 * FRAME;
    wait_until(t);
    chk("pre_rst_count", int'(cnt_a), 1);
    wait_until(t + 2 * 16 + 5);
    chk("pre_rst_cols", int'(cols_a), 32'hB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_a.delete();
    chk("mid_rst_cols", int'(cols_a), 32'hE);
    chk("mid_rst_valid", int'(valid_a), 0);
    chk("mid_rst_code", int'(code_a), 32'hFF);
    chk("mid_rst_count", int'(cnt_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
